// File: rtl/canvas_reader.sv
// Scans the 32x32 one-bit canvas RAM row by row, hands each packed row downstream
// over valid/ready, and accumulates ink count and bounding box for the whole scan.
`timescale 1ns/1ps
module canvas_reader (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        rd_en,
   output logic [9:0]  rd_addr,
   input  logic        rd_data,
   output logic        row_valid,
   input  logic        row_ready,
   output logic [4:0]  row_idx,
   output logic [31:0] row_data,
   output logic        busy,
   output logic        done,
   output logic [10:0] ink_count,
   output logic [4:0]  min_x,
   output logic [4:0]  max_x,
   output logic [4:0]  min_y,
   output logic [4:0]  max_y,
   output logic        empty
);

   typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;

   state_t      state, state_next;
   logic [5:0]  col;          // bit 5 set once all 32 reads of the row are issued
   logic [4:0]  row;
   logic        cap_valid;
   logic [4:0]  cap_col;
   logic [31:0] row_bits;
   logic [10:0] acc_count;
   logic [4:0]  acc_min_x, acc_max_x, acc_min_y, acc_max_y;
   logic        handshake;

   assign rd_en     = (state == READ) && !col[5];
   assign rd_addr   = rd_en ? {row, col[4:0]} : 10'd0;
   assign row_valid = (state == OUT);
   assign row_idx   = row;
   assign row_data  = row_bits;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign handshake = row_valid && row_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = READ;
         READ: if (cap_valid && (cap_col == 5'd31)) state_next = OUT;
         OUT:  if (handshake) state_next = (row == 5'd31) ? DONE : READ;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         cap_valid <= 1'b0;
         cap_col   <= '0;
         row_bits  <= '0;
         acc_count <= '0;
         acc_min_x <= 5'd31;
         acc_max_x <= '0;
         acc_min_y <= 5'd31;
         acc_max_y <= '0;
         ink_count <= '0;
         min_x     <= '0;
         max_x     <= '0;
         min_y     <= '0;
         max_y     <= '0;
         empty     <= 1'b1;
      end else begin
         cap_valid <= rd_en;
         cap_col   <= col[4:0];
         if (rd_en) col <= col + 6'd1;

         if (state == IDLE && start) begin
            col       <= '0;
            row       <= '0;
            cap_valid <= 1'b0;
            row_bits  <= '0;
            acc_count <= '0;
            acc_min_x <= 5'd31;
            acc_max_x <= '0;
            acc_min_y <= 5'd31;
            acc_max_y <= '0;
         end

         if (cap_valid) begin
            row_bits[cap_col] <= rd_data;
            if (rd_data) begin
               acc_count <= acc_count + 11'd1;
               if (cap_col < acc_min_x) acc_min_x <= cap_col;
               if (cap_col > acc_max_x) acc_max_x <= cap_col;
               if (row < acc_min_y)     acc_min_y <= row;
               if (row > acc_max_y)     acc_max_y <= row;
            end
         end

         if (handshake) begin
            col <= '0;
            if (row != 5'd31) begin
               row <= row + 5'd1;
            end else begin
               // Publish on entry to DONE so the stats are already valid during the done pulse
               ink_count <= acc_count;
               empty     <= (acc_count == 11'd0);
               min_x     <= (acc_count == 11'd0) ? 5'd0 : acc_min_x;
               max_x     <= (acc_count == 11'd0) ? 5'd0 : acc_max_x;
               min_y     <= (acc_count == 11'd0) ? 5'd0 : acc_min_y;
               max_y     <= (acc_count == 11'd0) ? 5'd0 : acc_max_y;
            end
         end
      end
   end

endmodule

// File: tb/tb_canvas_reader.sv
// Directed + randomized bench for canvas_reader: behavioural canvas RAM, per-scan
// reference rows/stats computed from the canvas contents, checked with immediate assertions.
`timescale 1ns/1ps
module tb_canvas_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic        rd_data;
   logic        row_valid;
   logic        row_ready;
   logic [4:0]  row_idx;
   logic [31:0] row_data;
   logic        busy;
   logic        done;
   logic [10:0] ink_count;
   logic [4:0]  min_x, max_x, min_y, max_y;
   logic        empty;

   canvas_reader dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx), .row_data(row_data),
      .busy(busy), .done(done), .ink_count(ink_count),
      .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y), .empty(empty)
   );

   always #5 clk = ~clk;

   logic mem [0:1023];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int nerr = 0;
   int nchk = 0;

   logic [31:0] exp_row [0:31];
   int exp_count, exp_minx, exp_maxx, exp_miny, exp_maxy, exp_empty;
   int prev_count = 0;
   int prev_empty = 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      nchk++;
      assert (obs === want) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic fill(input int mode);
      for (int a = 0; a < 1024; a++) begin
         case (mode)
            0: mem[a] = 1'b0;
            1: mem[a] = (a == 'h0E5);
            2: mem[a] = 1'b1;
            default: mem[a] = ($urandom_range(15) == 0);
         endcase
      end
   endtask

   // Reference: rows, count and bounding box straight from the canvas picture.
   task automatic compute_model();
      exp_count = 0; exp_minx = 32; exp_maxx = -1; exp_miny = 32; exp_maxy = -1;
      for (int y = 0; y < 32; y++) begin
         exp_row[y] = '0;
         for (int x = 0; x < 32; x++) begin
            if (mem[y*32 + x]) begin
               exp_row[y][x] = 1'b1;
               exp_count++;
               if (x < exp_minx) exp_minx = x;
               if (x > exp_maxx) exp_maxx = x;
               if (y < exp_miny) exp_miny = y;
               if (y > exp_maxy) exp_maxy = y;
            end
         end
      end
      exp_empty = (exp_count == 0);
      if (exp_empty) begin
         exp_minx = 0; exp_maxx = 0; exp_miny = 0; exp_maxy = 0;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_row_valid"}, row_valid, 0);
      chk({tag, "_row_idx"}, row_idx, 0);
      chk({tag, "_row_data"}, row_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ink_count"}, ink_count, 0);
      chk({tag, "_bounds"}, {min_x, max_x, min_y, max_y}, 0);
      chk({tag, "_empty"}, empty, 1);
   endtask

   task automatic run_scan(input string name, input int stall_row, input int stall_len,
                           input bit rand_ready, input int s1, input int s2, input int abort_row);
      int cyc, next_row, stalls, stalled, ndone;
      bit finished, rdy;
      compute_model();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; next_row = 0; stalls = 0; stalled = 0; ndone = 0; finished = 0;
      chk("busy_rise", busy, 1);
      chk("stats_held_count", ink_count, prev_count);
      chk("stats_held_empty", empty, prev_empty);
      while (!finished && cyc < 4000) begin
         start = (cyc == s1 || cyc == s2);
         if (abort_row >= 0 && rd_en && rd_addr == {abort_row[4:0], 5'd16}) begin
            #2 rst_n = 1'b0;
            #1 chk_reset_vals("async_reset");
            #3 rst_n = 1'b1;
            start = 1'b0;
            row_ready = 1'b1;
            prev_count = 0; prev_empty = 1;
            @(posedge clk); #1;
            chk("post_reset_idle", busy, 0);
            $display("scan %s: aborted by reset in row %0d at cycle %0d", name, abort_row, cyc);
            return;
         end
         rdy = 1'b1;
         if (row_valid) begin
            if (row_idx == stall_row[4:0] && stalled < stall_len) begin
               rdy = 1'b0; stalled++;
            end else if (rand_ready && $urandom_range(3) == 0) begin
               rdy = 1'b0;
            end
            chk("row_idx", row_idx, next_row);
            chk("row_data", row_data, (next_row < 32) ? exp_row[next_row] : 32'hDEAD_BEEF);
            if (rdy) next_row++;
            else begin
               stalls++;
               chk("rd_en_in_stall", rd_en, 0);
            end
         end
         row_ready = rdy;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               chk("done_cycle", cyc, 1089 + stalls);
               chk("rows_seen", next_row, 32);
               chk("ink_count", ink_count, exp_count);
               chk("empty", empty, exp_empty);
               chk("min_x", min_x, exp_minx);
               chk("max_x", max_x, exp_maxx);
               chk("min_y", min_y, exp_miny);
               chk("max_y", max_y, exp_maxy);
            end
         end else if (ndone > 0) begin
            chk("busy_fall", busy, 0);
            finished = 1'b1;
         end
         if (!finished) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk("scan_finished", finished, 1);
      chk("done_pulses", ndone, 1);
      start = 1'b0;
      row_ready = 1'b1;
      prev_count = exp_count; prev_empty = exp_empty;
      $display("scan %s: rows=%0d stalls=%0d done_pulses=%0d ink=%0d bbox=(%0d,%0d)-(%0d,%0d) empty=%0d",
               name, next_row, stalls, ndone, ink_count, min_x, min_y, max_x, max_y, empty);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; row_ready = 1'b1;
      fill(0);
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      fill(0); run_scan("empty", -1, 0, 0, -1, -1, -1);
      fill(1); run_scan("single_pixel", -1, 0, 0, -1, -1, -1);
      fill(2); run_scan("full", -1, 0, 0, -1, -1, -1);
      fill(3); run_scan("stall_row3", 3, 10, 0, -1, -1, -1);
      fill(3); run_scan("extra_starts", -1, 0, 0, 5, 500, -1);
      fill(3); run_scan("abort_row12", -1, 0, 0, -1, -1, 12);
      run_scan("after_abort", -1, 0, 0, -1, -1, -1);
      for (int k = 0; k < 2; k++) begin
         fill(3); run_scan("random_ready", -1, 0, 1, -1, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
